// File: rtl/ws2812b_pkg.sv
// Shared types and constants for the WS2812B strip arbiter.
package ws2812b_pkg;

    localparam int LEN_W_DEF   = 6;
    localparam int COLOR_W_DEF = 24;

    // Colour substituted when the owner withdraws its request mid-burst.
    localparam logic [COLOR_W_DEF-1:0] WS_BLACK = 24'h0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GRANT   = 3'd1,
        ST_FETCH   = 3'd2,
        ST_SEND    = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_WAITRDY = 3'd5,
        ST_DONE    = 3'd6,
        ST_GAP     = 3'd7
    } ws_state_e;

    // Requester index to one-hot owner vector.
    function automatic logic [1:0] idx_to_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ws2812b_rr_arb2.sv
// Two-way round-robin picker: remembers the last burst owner and, on
// contention, grants the requester that was not served last.
module ws2812b_rr_arb2
    import ws2812b_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic       upd_idx,
    output logic [1:0] grant
);

    logic last_r;

    // Last-owner pointer; reset value makes requester 0 win the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_r <= 1'b1;
        end else if (upd) begin
            last_r <= upd_idx;
        end else begin
            last_r <= last_r;
        end
    end

    // Pick the sole requester, or the one not served last on a tie.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_r ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/ws2812b_strip_arbiter.sv
// Shares one WS2812B serializer between two pixel requesters, granting
// whole bursts atomically with round-robin fairness and an idle gap.
module ws2812b_strip_arbiter
    import ws2812b_pkg::*;
#(
    parameter int LEN_W      = LEN_W_DEF,
    parameter int COLOR_W    = COLOR_W_DEF,
    parameter int GAP_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req_i,
    input  logic [LEN_W-1:0]   len0_i,
    input  logic [LEN_W-1:0]   len1_i,
    input  logic               latch0_i,
    input  logic               latch1_i,
    input  logic [COLOR_W-1:0] pix0_i,
    input  logic [COLOR_W-1:0] pix1_i,
    input  logic [1:0]         pix_valid_i,
    output logic [1:0]         pix_ready_o,
    output logic [1:0]         done_o,
    output logic [1:0]         grant_o,
    output logic               busy_o,
    output logic [COLOR_W-1:0] ws_data_o,
    output logic               ws_valid_o,
    output logic               ws_latch_o,
    input  logic               ws_ready_i
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

    ws_state_e          state_r, state_n;
    logic               owner_r, owner_n;
    logic [LEN_W-1:0]   rem_r, rem_n;
    logic               latch_r, latch_n;
    logic [COLOR_W-1:0] data_r, data_n;
    logic               drain_r, drain_n;
    logic [GAP_W-1:0]   gap_r, gap_n;
    logic [1:0]         pick_s;
    logic [1:0]         pix_ready_s;
    logic               rr_upd_s;
    logic [LEN_W-1:0]   sel_len_s;
    logic               sel_latch_s;
    logic [COLOR_W-1:0] sel_pix_s;
    logic               in_burst_s;

    ws2812b_rr_arb2 u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_i),
        .upd     (rr_upd_s),
        .upd_idx (owner_r),
        .grant   (pick_s)
    );

    assign sel_len_s   = owner_r ? len1_i   : len0_i;
    assign sel_latch_s = owner_r ? latch1_i : latch0_i;
    assign sel_pix_s   = owner_r ? pix1_i   : pix0_i;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            owner_r <= 1'b0;
            rem_r   <= '0;
            latch_r <= 1'b0;
            data_r  <= '0;
            drain_r <= 1'b0;
            gap_r   <= '0;
        end else begin
            state_r <= state_n;
            owner_r <= owner_n;
            rem_r   <= rem_n;
            latch_r <= latch_n;
            data_r  <= data_n;
            drain_r <= drain_n;
            gap_r   <= gap_n;
        end
    end

    // Next-state logic: burst sequencing and serializer handshake.
    always_comb begin
        state_n     = state_r;
        owner_n     = owner_r;
        rem_n       = rem_r;
        latch_n     = latch_r;
        data_n      = data_r;
        drain_n     = drain_r;
        gap_n       = gap_r;
        rr_upd_s    = 1'b0;
        pix_ready_s = 2'b00;
        case (state_r)
            ST_IDLE: begin
                if (pick_s != 2'b00) begin
                    owner_n = pick_s[1];
                    state_n = ST_GRANT;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_GRANT: begin
                rem_n   = sel_len_s;
                latch_n = sel_latch_s;
                if (sel_len_s == '0) begin
                    state_n = ST_DONE;
                end else begin
                    state_n = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // A withdrawn owner is not pulled; the rest of the burst goes out black.
                if (!req_i[owner_r]) begin
                    data_n  = COLOR_W'(WS_BLACK);
                    state_n = ST_SEND;
                end else begin
                    pix_ready_s = idx_to_onehot(owner_r);
                    if (pix_valid_i[owner_r]) begin
                        data_n  = sel_pix_s;
                        state_n = ST_SEND;
                    end else begin
                        state_n = ST_FETCH;
                    end
                end
            end
            ST_SEND: begin
                drain_n = 1'b0;
                if (ws_ready_i) begin
                    if (rem_r != '0) begin
                        rem_n = rem_r - LEN_W'(1);
                    end else begin
                        rem_n = rem_r;
                    end
                    state_n = ST_DRAIN;
                end else begin
                    state_n = ST_SEND;
                end
            end
            ST_DRAIN: begin
                // Ready staying high for two clocks means a zero-latency serializer.
                if (!ws_ready_i || drain_r) begin
                    state_n = ST_WAITRDY;
                end else begin
                    drain_n = 1'b1;
                    state_n = ST_DRAIN;
                end
            end
            ST_WAITRDY: begin
                if (!ws_ready_i) begin
                    state_n = ST_WAITRDY;
                end else if (rem_r != '0) begin
                    state_n = ST_FETCH;
                end else begin
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                rr_upd_s = 1'b1;
                gap_n    = '0;
                if (GAP_CYCLES == 0) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_r == GAP_LAST) begin
                    state_n = ST_IDLE;
                end else begin
                    gap_n   = gap_r + GAP_W'(1);
                    state_n = ST_GAP;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign in_burst_s  = (state_r != ST_IDLE) && (state_r != ST_GAP);
    assign grant_o     = in_burst_s ? idx_to_onehot(owner_r) : 2'b00;
    assign done_o      = (state_r == ST_DONE) ? idx_to_onehot(owner_r) : 2'b00;
    assign busy_o      = (state_r != ST_IDLE);
    assign pix_ready_o = pix_ready_s;
    assign ws_valid_o  = (state_r == ST_SEND);
    assign ws_latch_o  = (state_r == ST_SEND) && latch_r && (rem_r == LEN_W'(1));
    assign ws_data_o   = data_r;

endmodule
